// File: rtl/sort_pkg.sv
// Shared definitions for the hardware quicksort datapath: FSM states,
// bus-sizing limits and an element extractor for flattened arrays.
package sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FINAL_SWAP,
        DONE_ST,
        ERR_ST
    } sort_state_t;

    // Upper bounds for the generic element extractor; callers zero-extend
    // their flattened bus to MAX_BUS_W and truncate the result to DATA_W.
    localparam int MAX_ELEM_W = 64;
    localparam int MAX_BUS_W  = 4096;

    // Element k of a flattened bus with w-bit elements (element 0 in the LSBs).
    function automatic logic [MAX_ELEM_W-1:0] elem_get(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        return MAX_ELEM_W'(bus >> (k * w));
    endfunction

endpackage

// File: rtl/sort_cmp.sv
// Combinational element-vs-pivot compare. take=1 means the element belongs
// on the left of the pivot: a <= pivot, or a >= pivot when DESCENDING.
module sort_cmp
    import sort_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SIGNED     = 0,
    parameter int DESCENDING = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] pivot,
    output logic              take
);

    logic le;
    logic ge;

    generate
        if (SIGNED != 0) begin : g_signed
            assign le = $signed(a) <= $signed(pivot);
            assign ge = $signed(a) >= $signed(pivot);
        end else begin : g_unsigned
            assign le = a <= pivot;
            assign ge = a >= pivot;
        end
    endgenerate

    assign take = (DESCENDING != 0) ? ge : le;

endmodule

// File: rtl/lomuto_partitioner.sv
// Lomuto partition engine: partitions arr[lo..hi] around arr[hi], one
// element per clock, then swaps the pivot into place and reports its index.
module lomuto_partitioner
    import sort_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_W     = 8,
    parameter int IDX_W      = $clog2(N),
    parameter int SIGNED     = 0,
    parameter int DESCENDING = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [IDX_W-1:0]    lo,
    input  logic [IDX_W-1:0]    hi,
    input  logic [N*DATA_W-1:0] array_in,
    output logic [N*DATA_W-1:0] array_out,
    output logic [IDX_W-1:0]    pivot_idx,
    output logic [IDX_W:0]      swap_cnt,
    output logic                busy,
    output logic                done,
    output logic                err
);

    sort_state_t                  state;
    sort_state_t                  state_nxt;
    logic [N-1:0][DATA_W-1:0]     arr;
    logic [DATA_W-1:0]            pivot;
    logic [IDX_W-1:0]             i_q;
    logic [IDX_W-1:0]             j_q;
    logic [IDX_W-1:0]             hi_q;
    logic [IDX_W-1:0]             hi_m1;
    logic                         take;
    logic                         range_bad;
    logic                         accept;

    // hi is checked against N as well since IDX_W can address past N
    // when N is not a power of two.
    assign range_bad = (lo > hi) || ({1'b0, hi} >= (IDX_W+1)'(N));
    assign accept    = (state == IDLE) && start;
    assign hi_m1     = hi_q - IDX_W'(1);
    assign array_out = arr;

    sort_cmp #(
        .DATA_W     (DATA_W),
        .SIGNED     (SIGNED),
        .DESCENDING (DESCENDING)
    ) u_cmp (
        .a     (arr[j_q]),
        .pivot (pivot),
        .take  (take)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: the scan ends once j==hi-1 has been compared.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (range_bad)     state_nxt = ERR_ST;
                    else if (lo == hi) state_nxt = FINAL_SWAP;
                    else               state_nxt = SCAN;
                end
            end
            SCAN:       if (j_q == hi_m1) state_nxt = FINAL_SWAP;
            FINAL_SWAP: state_nxt = DONE_ST;
            DONE_ST:    state_nxt = IDLE;
            ERR_ST:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath: load, swap-on-take scan, final pivot swap, status flags.
    // done/err are registered off the terminal states, so busy is held one
    // extra cycle to cover the done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arr       <= '0;
            pivot     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            hi_q      <= '0;
            pivot_idx <= '0;
            swap_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == DONE_ST) || (state == ERR_ST);
            err  <= (state == ERR_ST);
            busy <= (accept && !range_bad) || (state == SCAN) ||
                    (state == FINAL_SWAP) || (state == DONE_ST);
            case (state)
                IDLE: begin
                    if (start && !range_bad) begin
                        arr      <= array_in;
                        pivot    <= DATA_W'(elem_get(MAX_BUS_W'(array_in),
                                                     int'(hi), DATA_W));
                        i_q      <= lo;
                        j_q      <= lo;
                        hi_q     <= hi;
                        swap_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        // i==j degenerates to rewriting the same value.
                        arr[i_q] <= arr[j_q];
                        arr[j_q] <= arr[i_q];
                        i_q      <= i_q + IDX_W'(1);
                        swap_cnt <= swap_cnt + (IDX_W+1)'(1);
                    end
                    j_q <= j_q + IDX_W'(1);
                end
                FINAL_SWAP: begin
                    arr[i_q]  <= arr[hi_q];
                    arr[hi_q] <= arr[i_q];
                    pivot_idx <= i_q;
                end
                default: ;
            endcase
        end
    end

endmodule
